// File: rtl/vram_arb_pkg.sv
// Shared types and default sizing for the text-mode VRAM arbiter.
package vram_arb_pkg;

  localparam int unsigned VRAM_AW       = 13;
  localparam int unsigned VRAM_DW       = 8;
  localparam int unsigned VRAM_MAX_WAIT = 4;
  localparam int unsigned VRAM_WW       = 3;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } own_t;

endpackage

// File: rtl/vram_arb_if.sv
// CPU, VGA and VRAM-side signals of the arbiter, bundled as one interface.
interface vram_arb_if #(
  parameter int unsigned AW = vram_arb_pkg::VRAM_AW,
  parameter int unsigned DW = vram_arb_pkg::VRAM_DW
) ();

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ack;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;

  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    output cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_rdata,
    input  cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
           ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/arb_wait_counter.sv
// Counts consecutive cycles a pending CPU request loses; force_cpu is set
// once MAX_WAIT losses have accumulated so the next arbitration goes to the CPU.
module arb_wait_counter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WW       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic cpu_ack,
  output logic force_cpu
);

  logic [WW-1:0] cnt;
  logic [WW-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (!cpu_req || cpu_ack) begin
      cnt_n = '0;
    end else if (cnt != WW'(MAX_WAIT)) begin
      cnt_n = cnt + WW'(1);
    end
  end

  // force_cpu is kept as a flop tracking cnt == MAX_WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      force_cpu <= 1'b0;
    end else begin
      cnt       <= cnt_n;
      force_cpu <= (cnt_n == WW'(MAX_WAIT));
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA fetch has priority, CPU is guaranteed a grant
// after MAX_WAIT lost cycles; read data returns two cycles after acceptance.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = VRAM_MAX_WAIT,
  parameter int unsigned WW       = VRAM_WW
) (
  input  logic           clk,
  input  logic           rst,
  vram_arb_if.slave      bus
);

  logic force_cpu;
  logic vga_win;
  logic cpu_win;
  own_t tag1_q;
  own_t tag2_q;
  own_t tag1_n;
  own_t tag2_n;

  // Combinational arbitration; nothing is granted while in reset
  always_comb begin
    vga_win = 1'b0;
    cpu_win = 1'b0;
    if (!rst) begin
      vga_win = bus.vga_req && !(force_cpu && bus.cpu_req);
      cpu_win = bus.cpu_req && !vga_win;
    end
  end

  assign bus.vga_ack = vga_win;
  assign bus.cpu_ack = cpu_win;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT),
    .WW       (WW)
  ) u_wait (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (bus.cpu_req),
    .cpu_ack   (cpu_win),
    .force_cpu (force_cpu)
  );

  // Owner tags track which requester a read in flight belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_q <= OWN_NONE;
      tag2_q <= OWN_NONE;
    end else begin
      tag1_q <= tag1_n;
      tag2_q <= tag2_n;
    end
  end

  always_comb begin
    tag1_n = OWN_NONE;
    tag2_n = tag1_q;
    if (vga_win) begin
      tag1_n = OWN_VGA;
    end else if (cpu_win && !bus.cpu_we) begin
      tag1_n = OWN_CPU;
    end
  end

  // Registered RAM command; address and write data hold when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
    end else if (vga_win) begin
      bus.ram_en    <= 1'b1;
      bus.ram_we    <= 1'b0;
      bus.ram_addr  <= bus.vga_addr;
    end else if (cpu_win) begin
      bus.ram_en    <= 1'b1;
      bus.ram_we    <= bus.cpu_we;
      bus.ram_addr  <= bus.cpu_addr;
      bus.ram_wdata <= bus.cpu_wdata;
    end else begin
      bus.ram_en    <= 1'b0;
      bus.ram_we    <= 1'b0;
    end
  end

  assign bus.cpu_rvalid = (tag2_q == OWN_CPU);
  assign bus.vga_rvalid = (tag2_q == OWN_VGA);
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.vga_rdata  = bus.ram_rdata;

endmodule
